// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer -- instruction step sequencer for the tiny16 core.
//
// Owns the step counter and walks it through the fetch steps
// (0..FETCH_STEPS-1) and the execute steps (FETCH_STEPS..MAX_STEP). It also
// handles run/stop/halt.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         begin/resume execution from IDLE or HALT (level)
//   stop_i          request a stop at the next instruction boundary
//   mem_ack_i       fetch read completed (only looked at in fetch step 0)
//   stall_i         decoder stall; freezes execute
//   last_step_i     decoder: current step ends the instruction
//   hlt_i           decoder: current instruction is HLT
//   step_o          registered step counter
//   mem_req_o       fetch read request (FETCH and step 0)
//   fetch_o/exec_o  phase indicators
//   running_o       FETCH or EXEC
//   halted_o        HALT
//   step_ovf_o      sticky: an instruction ran past MAX_STEP w/o last_step
//   instr_cnt_o     retired-instruction count
//
// Configuration: define STEP_SEQ_ICOUNT_EN to build the 16-bit
// retired-instruction counter; otherwise instr_cnt_o is tied to 0.
// ---------------------------------------------------------------------------
module step_sequencer #(
  parameter int STEP_W      = 3,
  parameter int MAX_STEP    = 7,
  parameter int FETCH_STEPS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              mem_ack_i,
  input  logic              stall_i,
  input  logic              last_step_i,
  input  logic              hlt_i,
  output logic [STEP_W-1:0] step_o,
  output logic              mem_req_o,
  output logic              fetch_o,
  output logic              exec_o,
  output logic              running_o,
  output logic              halted_o,
  output logic              step_ovf_o,
  output logic [15:0]       instr_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [STEP_W-1:0] LAST_FETCH = STEP_W'(FETCH_STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_MAX   = STEP_W'(MAX_STEP);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                stop_q, stop_d;
  logic                ovf_q, ovf_d;
  logic                retire;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      stop_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      stop_q  <= stop_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    stop_d  = stop_q;
    ovf_d   = ovf_q;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (start_i) begin
          state_d = S_FETCH;
          step_d  = '0;
        end
      end
      S_FETCH: begin
        if (stop_i) stop_d = 1'b1;
        // Step 0 waits for memory; later fetch steps advance freely.
        if (step_q != '0 || mem_ack_i) begin
          step_d = step_q + 1'b1;
          if (step_q == LAST_FETCH) state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (stop_i) stop_d = 1'b1;
        if (!stall_i) begin
          if (hlt_i) begin
            state_d = S_HALT;
            step_d  = '0;
            stop_d  = 1'b0;
            retire  = 1'b1;
          end else if (last_step_i || step_q == STEP_MAX) begin
            retire = 1'b1;
            step_d = '0;
            if (!last_step_i) ovf_d = 1'b1;
            // A stop arriving on the retiring cycle itself still counts
            // for this boundary rather than being dropped.
            state_d = (stop_q || stop_i) ? S_IDLE : S_FETCH;
            stop_d  = 1'b0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      S_HALT: begin
        step_d = '0;
        if (start_i) state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    fetch_o   = (state_q == S_FETCH);
    exec_o    = (state_q == S_EXEC);
    running_o = fetch_o | exec_o;
    halted_o  = (state_q == S_HALT);
    mem_req_o = fetch_o && (step_q == '0);
  end

  assign step_o     = step_q;
  assign step_ovf_o = ovf_q;

`ifdef STEP_SEQ_ICOUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 16'd1;
  end

  assign instr_cnt_o = cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instr_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;
  localparam int FS = 2;
  localparam int MX = 7;
`ifdef STEP_SEQ_ICOUNT_EN
  localparam bit ICNT_ON = 1'b1;
`else
  localparam bit ICNT_ON = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 0, stop = 0, mem_ack = 0, stall = 0, last_step = 0, hlt = 0;
  logic [2:0] step;
  logic mem_req, fetch, exec, running, halted, step_ovf;
  logic [15:0] instr_cnt;

  int checks = 0, failures = 0;

  step_sequencer #(.STEP_W(3), .MAX_STEP(MX), .FETCH_STEPS(FS)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop),
    .mem_ack_i(mem_ack), .stall_i(stall), .last_step_i(last_step), .hlt_i(hlt),
    .step_o(step), .mem_req_o(mem_req), .fetch_o(fetch), .exec_o(exec),
    .running_o(running), .halted_o(halted), .step_ovf_o(step_ovf),
    .instr_cnt_o(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // {step, mem_req, fetch, exec, running, halted, step_ovf}
  function automatic logic [8:0] outs();
    return {step, mem_req, fetch, exec, running, halted, step_ovf};
  endfunction

  function automatic logic [8:0] mk_out(input int s, input bit r, input bit f,
                                        input bit x, input bit h, input bit o);
    logic [2:0] s3;
    s3 = 3'(s);
    return {s3, r, f, x, f | x, h, o};
  endfunction

  function automatic logic [15:0] ecnt(input int n);
    return ICNT_ON ? 16'(n) : 16'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit st, input bit sp, input bit ak,
                        input bit sl, input bit ls, input bit hl);
    start = st; stop = sp; mem_ack = ak; stall = sl; last_step = ls; hlt = hl;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    bit st, sp, ak, sl, ls, hl;
    int e_step; bit e_req, e_f, e_x, e_h; int e_cnt;
  } vec_t;

  // Reference model: phase is derived from the step number, not a state code.
  bit m_active, m_halt, m_stopl, m_ovf;
  int m_step, m_cnt;

  task automatic model_step();
    if (m_halt) begin
      if (start) begin m_halt = 0; m_active = 1; m_step = 0; end
    end else if (!m_active) begin
      m_stopl = 0;
      if (start) begin m_active = 1; m_step = 0; end
    end else begin
      bit stop_seen;
      stop_seen = m_stopl || stop;
      if (stop) m_stopl = 1;
      if (m_step < FS) begin
        if (m_step != 0 || mem_ack) m_step++;
      end else if (!stall) begin
        if (hlt) begin
          m_halt = 1; m_active = 0; m_step = 0; m_stopl = 0; m_cnt++;
        end else if (last_step || m_step == MX) begin
          if (!last_step) m_ovf = 1;
          m_cnt++; m_step = 0; m_stopl = 0;
          if (stop_seen) m_active = 0;
        end else m_step++;
      end
    end
  endtask

  function automatic logic [8:0] model_out();
    bit f, x;
    f = m_active && (m_step < FS);
    x = m_active && (m_step >= FS);
    return mk_out(m_step, f && m_step == 0, f, x, m_halt, m_ovf);
  endfunction

  vec_t tv[13];

  initial begin
    //        st sp ak sl ls hl  step req f  x  h  cnt
    tv[0]  = '{1, 0, 1, 0, 0, 0,  0,  1,  1, 0, 0, 0};
    tv[1]  = '{0, 0, 1, 0, 0, 0,  1,  0,  1, 0, 0, 0};
    tv[2]  = '{0, 0, 1, 0, 0, 0,  2,  0,  0, 1, 0, 0};
    tv[3]  = '{0, 0, 1, 0, 0, 0,  3,  0,  0, 1, 0, 0};
    tv[4]  = '{0, 0, 1, 0, 0, 0,  4,  0,  0, 1, 0, 0};
    tv[5]  = '{0, 0, 1, 0, 1, 0,  0,  1,  1, 0, 0, 1};
    tv[6]  = '{0, 0, 1, 0, 0, 0,  1,  0,  1, 0, 0, 1};
    tv[7]  = '{0, 0, 1, 0, 0, 0,  2,  0,  0, 1, 0, 1};
    tv[8]  = '{0, 0, 1, 0, 0, 0,  3,  0,  0, 1, 0, 1};
    tv[9]  = '{0, 0, 1, 0, 1, 1,  0,  0,  0, 0, 1, 2};
    tv[10] = '{0, 0, 1, 0, 0, 0,  0,  0,  0, 0, 1, 2};
    tv[11] = '{1, 0, 1, 0, 0, 0,  0,  1,  1, 0, 0, 2};
    tv[12] = '{0, 0, 0, 0, 0, 0,  0,  1,  1, 0, 0, 2};

    // Reset state
    #2;
    chk("reset_outs", 32'(outs()), 32'(mk_out(0, 0, 0, 0, 0, 0)));
    chk("reset_cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Normal instruction, then HLT priority and restart
    for (int i = 0; i < 13; i++) begin
      set_in(tv[i].st, tv[i].sp, tv[i].ak, tv[i].sl, tv[i].ls, tv[i].hl);
      tick();
      chk($sformatf("vec%0d_outs", i), 32'(outs()),
          32'(mk_out(tv[i].e_step, tv[i].e_req, tv[i].e_f, tv[i].e_x, tv[i].e_h, 0)));
      chk($sformatf("vec%0d_cnt", i), 32'(instr_cnt), 32'(ecnt(tv[i].e_cnt)));
    end

    // Memory wait: step 0 already held one cycle; three more, then ack
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("memwait_hold", 32'({step, mem_req}), 32'({3'd0, 1'b1}));
    end
    mem_ack = 1;
    tick();
    chk("memwait_adv", 32'({step, mem_req, fetch}), 32'({3'd1, 1'b0, 1'b1}));

    // Stop pulse at step 2, stall at step 3 with last_step
    tick();
    chk("ss_step2", 32'(outs()), 32'(mk_out(2, 0, 0, 1, 0, 0)));
    stop = 1;
    tick();
    stop = 0;
    stall = 1; last_step = 1;
    for (int i = 0; i < 2; i++) begin
      chk("ss_hold3", 32'(outs()), 32'(mk_out(3, 0, 0, 1, 0, 0)));
      tick();
    end
    chk("ss_hold3", 32'(outs()), 32'(mk_out(3, 0, 0, 1, 0, 0)));
    stall = 0;
    tick();
    last_step = 0;
    chk("ss_idle", 32'(outs()), 32'(mk_out(0, 0, 0, 0, 0, 0)));
    chk("ss_cnt", 32'(instr_cnt), 32'(ecnt(3)));
    tick();
    chk("ss_stay_idle", 32'(running), 32'd0);

    // Overflow: no last_step, runs to MAX_STEP and is force-retired
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < MX; i++) tick();
    chk("ovf_at_max", 32'(outs()), 32'(mk_out(MX, 0, 0, 1, 0, 0)));
    tick();
    chk("ovf_retire", 32'(outs()), 32'(mk_out(0, 1, 1, 0, 0, 1)));
    chk("ovf_cnt", 32'(instr_cnt), 32'(ecnt(4)));
    tick(); tick();
    last_step = 1;
    tick();
    last_step = 0;
    chk("ovf_sticky", 32'(outs()), 32'(mk_out(0, 1, 1, 0, 0, 1)));
    chk("ovf_cnt2", 32'(instr_cnt), 32'(ecnt(5)));

    // Async reset mid-EXEC at step 5
    for (int i = 0; i < 5; i++) tick();
    chk("ar_pre", 32'(step), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_outs", 32'(outs()), 32'(mk_out(0, 0, 0, 0, 0, 0)));
    chk("ar_cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the reference model
    do_reset();
    m_active = 0; m_halt = 0; m_stopl = 0; m_ovf = 0; m_step = 0; m_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      set_in($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(1) == 1,
             $urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(39) == 0);
      model_step();
      tick();
      chk($sformatf("rnd%0d_outs", c), 32'(outs()), 32'(model_out()));
      chk($sformatf("rnd%0d_cnt", c), 32'(instr_cnt), 32'(ecnt(m_cnt & 16'hFFFF)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
